// File: rtl/gray_sync_rx_if.sv
// rtl/gray_sync_rx_if.sv - gray-coded CDC receive bundle: foreign-domain input plus decoded outputs
interface gray_sync_rx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] gray_in;
    logic [WIDTH-1:0] gray_sync;
    logic [WIDTH-1:0] bin_out;
    logic             upd;
    logic [WIDTH-1:0] delta;
    logic             err;
    logic [7:0]       err_cnt;

    modport master (
        output gray_in,
        input  gray_sync, bin_out, upd, delta, err, err_cnt
    );

    modport slave (
        input  gray_in,
        output gray_sync, bin_out, upd, delta, err, err_cnt
    );
endinterface

// File: rtl/gray_sync_rx.sv
// rtl/gray_sync_rx.sv - gray-coded counter synchronizer with binary decode, step pulses and error count
module gray_sync_rx #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    gray_sync_rx_if.slave  bus
);
    localparam int FILL_W = $clog2(SYNC_STAGES + 2);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]  sync [SYNC_STAGES];
    logic [WIDTH-1:0]  gray_sync;
    logic [WIDTH-1:0]  gray_prev;
    logic [WIDTH-1:0]  diff;
    logic [WIDTH-1:0]  bin_new;
    logic [WIDTH-1:0]  bin_prev;
    logic              multi_flip;
    logic              primed;
    logic [FILL_W-1:0] fill;

    logic [WIDTH-1:0]  bin_q;
    logic [WIDTH-1:0]  delta_q;
    logic              upd_q;
    logic              err_q;
    logic [7:0]        err_cnt_q;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync[i] <= '0;
            end
        end else begin
            sync[0] <= bus.gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    assign gray_sync  = sync[SYNC_STAGES-1];
    assign diff       = gray_sync ^ gray_prev;
    assign multi_flip = |(diff & (diff - WIDTH'(1)));
    assign bin_new    = gray2bin(gray_sync);
    assign bin_prev   = gray2bin(gray_prev);
    assign primed     = (fill == FILL_DONE);

    // Priming runs until the chain has flushed reset zeros and gray_prev holds a real sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill      <= '0;
            gray_prev <= '0;
            bin_q     <= '0;
            delta_q   <= '0;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (!primed) begin
            fill      <= fill + FILL_W'(1);
            gray_prev <= gray_sync;
            bin_q     <= bin_new;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
        end else if (diff != '0) begin
            gray_prev <= gray_sync;
            bin_q     <= bin_new;
            delta_q   <= bin_new - bin_prev;
            upd_q     <= 1'b1;
            err_q     <= multi_flip;
            if (multi_flip && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end else begin
            upd_q <= 1'b0;
            err_q <= 1'b0;
        end
    end

    assign bus.gray_sync = gray_sync;
    assign bus.bin_out   = bin_q;
    assign bus.delta     = delta_q;
    assign bus.upd       = upd_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_gray_sync_rx.sv
// tb/tb_gray_sync_rx.sv - randomized and directed bench for gray_sync_rx against a delay-line reference
`timescale 1ns/100ps
module tb_gray_sync_rx;
    localparam int W = 4;
    localparam int S = 2;

    logic clk;
    logic rst_n;
    gray_sync_rx_if #(.WIDTH(W)) bus ();

    gray_sync_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int upd_seen = 0;
    int err_seen = 0;
    bit checking = 0;

    initial clk = 1'b0;
    always #17.5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] dec(input logic [W-1:0] g);
        logic [W-1:0] b = g;
        for (int i = 1; i < W; i++) b ^= (g >> i);
        return b;
    endfunction

    function automatic logic [W-1:0] enc(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference: history of gray_in sampled at each edge; outputs follow from the rules on that history.
    logic [W-1:0] q[$];
    int           n_edges = 0;
    logic [W-1:0] e_gs = '0, e_bin = '0, e_delta = '0;
    logic         e_upd = 1'b0, e_err = 1'b0;
    int           e_cnt = 0;

    task automatic model_clear();
        q = {};
        for (int i = 0; i < S + 2; i++) q.push_back('0);
        n_edges = 0;
        e_gs = '0; e_bin = '0; e_delta = '0; e_upd = 1'b0; e_err = 1'b0; e_cnt = 0;
    endtask

    initial model_clear();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            q.push_front(bus.gray_in);
            while (q.size() > S + 2) void'(q.pop_back());
            if (n_edges < 1000) n_edges++;
            e_gs = q[S-1];
            if (n_edges <= S + 1) begin
                e_upd = 1'b0;
                e_err = 1'b0;
                e_bin = dec(q[S]);
            end else if (q[S] != q[S+1]) begin
                e_upd   = 1'b1;
                e_err   = ($countones(q[S] ^ q[S+1]) > 1);
                e_bin   = dec(q[S]);
                e_delta = dec(q[S]) - dec(q[S+1]);
                if (e_err && e_cnt < 255) e_cnt++;
            end else begin
                e_upd = 1'b0;
                e_err = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("gray_sync", 32'(bus.gray_sync), 32'(e_gs));
            chk("bin_out",   32'(bus.bin_out),   32'(e_bin));
            chk("upd",       32'(bus.upd),       32'(e_upd));
            chk("err",       32'(bus.err),       32'(e_err));
            chk("delta",     32'(bus.delta),     32'(e_delta));
            chk("err_cnt",   32'(bus.err_cnt),   32'(e_cnt));
            if (bus.upd === 1'b1) upd_seen++;
            if (bus.err === 1'b1) err_seen++;
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #3;
    endtask

    task automatic do_reset(input logic [W-1:0] g);
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        bus.gray_in = g;
        #1;
        chk("rst_gray_sync", 32'(bus.gray_sync), 0);
        chk("rst_bin_out",   32'(bus.bin_out),   0);
        chk("rst_upd",       32'(bus.upd),       0);
        chk("rst_err",       32'(bus.err),       0);
        chk("rst_delta",     32'(bus.delta),     0);
        chk("rst_err_cnt",   32'(bus.err_cnt),   0);
        repeat (2) @(posedge clk);
        #5;
        rst_n = 1'b1;
        upd_seen = 0;
        err_seen = 0;
        cyc(6);
        chk("rst_quiet_upd", 32'(upd_seen), 0);
        chk("rst_quiet_err", 32'(err_seen), 0);
        chk("rst_load_bin",  32'(bus.bin_out), 32'(dec(g)));
    endtask

    logic [W-1:0] b;

    initial begin
        rst_n = 1'b0;
        bus.gray_in = 4'b0110;
        @(posedge clk);
        #3;
        checking = 1;
        repeat (2) @(posedge clk);
        #5;
        rst_n = 1'b1;
        upd_seen = 0;
        err_seen = 0;
        cyc(3);
        chk("prime_bin", 32'(bus.bin_out), 32'h4);
        cyc(5);
        chk("prime_upd", 32'(upd_seen), 0);
        chk("prime_err", 32'(err_seen), 0);
        chk("prime_cnt", 32'(bus.err_cnt), 0);

        // Slow forward count with a 100 ns source clock, wrapping 15 -> 0.
        do_reset('0);
        @(posedge clk);
        #3;
        for (int i = 1; i <= 16; i++) begin
            b = W'(i);
            bus.gray_in = enc(b);
            #100;
        end
        cyc(6);
        chk("fwd_upd",   32'(upd_seen), 16);
        chk("fwd_err",   32'(err_seen), 0);
        chk("fwd_bin",   32'(bus.bin_out), 0);
        chk("fwd_delta", 32'(bus.delta), 1);

        do_reset(4'b0011);
        bus.gray_in = 4'b0001;
        cyc(6);
        chk("back_upd",   32'(upd_seen), 1);
        chk("back_err",   32'(err_seen), 0);
        chk("back_delta", 32'(bus.delta), 32'hF);
        chk("back_bin",   32'(bus.bin_out), 1);

        upd_seen = 0;
        err_seen = 0;
        bus.gray_in = 4'b0011;
        #10;
        bus.gray_in = 4'b0010;
        cyc(6);
        chk("skip_upd",   32'(upd_seen), 1);
        chk("skip_err",   32'(err_seen), 1);
        chk("skip_delta", 32'(bus.delta), 2);
        chk("skip_bin",   32'(bus.bin_out), 3);
        chk("skip_cnt",   32'(bus.err_cnt), 1);

        do_reset('0);
        for (int i = 0; i < 260; i++) begin
            bus.gray_in = bus.gray_in ^ 4'b0011;
            cyc(2);
        end
        cyc(4);
        chk("sat_cnt", 32'(bus.err_cnt), 255);
        chk("sat_upd", 32'(upd_seen), 260);
        chk("sat_err", 32'(err_seen), 260);

        b = W'($urandom_range(0, 15));
        do_reset(enc(b));
        for (int i = 0; i < 600; i++) begin
            int r;
            if (i == 300) begin
                b = W'($urandom_range(0, 15));
                do_reset(enc(b));
            end
            r = int'($urandom_range(0, 9));
            if (r >= 4 && r <= 5) b = b + W'(1);
            else if (r >= 6 && r <= 7) b = b - W'(1);
            else if (r >= 8) b = W'($urandom_range(0, 15));
            bus.gray_in = enc(b);
            cyc(1);
        end
        cyc(6);
        chk("rand_final_bin", 32'(bus.bin_out), 32'(b));

        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
